// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates an instruction-fetch port and a data port onto
// a single memory with fixed read latency MEM_LAT. One transaction is in
// flight at a time: IDLE -> ACCESS -> WAIT (MEM_LAT-1 cycles) -> RESP.
// Data wins contested arbitration. Optional macro STARVE_GUARD_EN adds a
// saturating counter that forces fetch to win after STARVE_MAX contested losses.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_lat_cnt;
  logic                r_win_if;
  logic                r_we;
  logic                r_if_gnt, r_d_gnt, r_if_valid, r_d_valid;
  logic                r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata, r_d_rdata;
  logic                w_arb, w_force, w_fetch_wins, w_enter_resp;

  assign w_arb        = (r_state == S_IDLE) && (if_req || d_req);
  assign w_fetch_wins = if_req && (!d_req || w_force);
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

`ifdef STARVE_GUARD_EN
  logic [3:0] r_starve;
  logic       w_contested;

  assign w_contested = if_req && d_req;
  assign w_force     = (r_starve == 4'(STARVE_MAX));

  // Starvation counter: counts contested fetch losses, cleared on any fetch grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_arb) begin
      if (w_fetch_wins)
        r_starve <= '0;
      else if (w_contested && (r_starve != 4'(STARVE_MAX)))
        r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (if_req || d_req) w_next = S_ACCESS;
      S_ACCESS: w_next = (MEM_LAT == 1) ? S_RESP : S_WAIT;
      S_WAIT:   if (r_lat_cnt == 4'(MEM_LAT - 1)) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered outputs and latched transaction; grant/strobe are set on the
  // edge entering ACCESS and valid/rdata on the edge entering RESP, so each
  // appears during the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt   <= '0;
      r_win_if    <= 1'b0;
      r_we        <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_gnt   <= w_arb && w_fetch_wins;
      r_d_gnt    <= w_arb && !w_fetch_wins;
      r_mem_en   <= w_arb;
      r_mem_we   <= w_arb && !w_fetch_wins && d_we;
      r_if_valid <= w_enter_resp && r_win_if;
      r_d_valid  <= w_enter_resp && !r_win_if;
      if (w_arb) begin
        r_win_if    <= w_fetch_wins;
        r_we        <= !w_fetch_wins && d_we;
        r_mem_addr  <= w_fetch_wins ? if_addr : d_addr;
        r_mem_wdata <= w_fetch_wins ? '0 : d_wdata;
      end
      if (r_state == S_ACCESS)
        r_lat_cnt <= 4'd1;
      else if (r_state == S_WAIT)
        r_lat_cnt <= r_lat_cnt + 4'd1;
      if (w_enter_resp && !r_we) begin
        if (r_win_if) r_if_rdata <= mem_rdata;
        else          r_d_rdata  <= mem_rdata;
      end
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level reference model
// predicts, per arbitration, the grant cycle, response cycle, memory command
// and returned data from cycle arithmetic; every output is compared each cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] fill(input int unsigned i);
    fill = (i == 16) ? 16'hA5A5 : 16'((i * 32'h9E37) ^ 32'h3C5A);
  endfunction

  // Memory stub: word is valid only in the cycle MEM_LAT-1 after ACCESS
  // (ACCESS itself when LAT=1); any other cycle returns the inverted word.
  logic [DW-1:0] smem [256];
  logic [AW-1:0] cap_addr = '0;
  int unsigned   k = 0;
  bit            filled = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      if (!filled) begin
        for (int unsigned i = 0; i < 256; i++) smem[i] <= fill(i);
        filled <= 1'b1;
      end
    end else if (mem_en) begin
      k <= 1;
      cap_addr <= mem_addr;
      if (mem_we) smem[mem_addr[7:0]] <= mem_wdata;
    end else if (k != 0 && k < 40) begin
      k <= k + 1;
    end
  end
  always_comb begin
    mem_rdata = '0;
    if (LAT == 1) mem_rdata = mem_en ? smem[mem_addr[7:0]] : ~smem[mem_addr[7:0]];
    else          mem_rdata = (k == LAT - 1) ? smem[cap_addr[7:0]] : ~smem[cap_addr[7:0]];
  end

  // Reference model state
  int            cyc = 0, next_idle = 0, g_cyc = -1, v_cyc = -1, starve = 0;
  bit            m_if, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd, e_if_rdata, e_d_rdata;
  logic [DW-1:0] rmem [256];
  bit            if_pend = 0, d_pend = 0;
  int unsigned   p_if = 0, p_d = 0;
  int            n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", tag, act, exp, cyc, $time);
    end
  endtask

  task automatic check_cycle();
    bit acc, rsp;
    acc = (cyc == g_cyc);
    rsp = (cyc == v_cyc);
    check("if_gnt", 32'(if_gnt), 32'(acc && m_if));
    check("d_gnt", 32'(d_gnt), 32'(acc && !m_if));
    check("mem_en", 32'(mem_en), 32'(acc));
    check("busy", 32'(busy), 32'(cyc >= g_cyc && cyc <= v_cyc));
    if (acc) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    check("if_valid", 32'(if_valid), 32'(rsp && m_if));
    check("d_valid", 32'(d_valid), 32'(rsp && !m_if));
    if (rsp && !m_we) begin
      if (m_if) e_if_rdata = m_rd;
      else      e_d_rdata  = m_rd;
    end
    check("if_rdata", 32'(if_rdata), 32'(e_if_rdata));
    check("d_rdata", 32'(d_rdata), 32'(e_d_rdata));
  endtask

  task automatic drive_inputs();
    if (cyc == g_cyc && m_if)  if_pend = 0;
    if (cyc == g_cyc && !m_if) d_pend = 0;
    if (!if_pend) begin
      if_addr = 16'($urandom);
      if ($urandom_range(99) < p_if) if_pend = 1;
    end
    if (!d_pend) begin
      d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom_range(1));
      if ($urandom_range(99) < p_d) d_pend = 1;
    end
    if_req = if_pend;
    d_req  = d_pend;
  endtask

  task automatic model_arb();
    bit contested;
    if (cyc >= next_idle && (if_req || d_req)) begin
      contested = if_req && d_req;
      m_if = if_req && (!d_req || (GUARD && starve == SMAX));
      if (m_if) starve = 0;
      else if (contested && starve < SMAX) starve = starve + 1;
      m_we    = !m_if && d_we;
      m_addr  = m_if ? if_addr : d_addr;
      m_wdata = m_if ? '0 : d_wdata;
      if (m_we) rmem[m_addr[7:0]] = m_wdata;
      else      m_rd = rmem[m_addr[7:0]];
      g_cyc = cyc + 1;
      v_cyc = cyc + 1 + LAT;
      next_idle = cyc + LAT + 2;
    end
  endtask

  task automatic cycle_body();
    check_cycle();
    drive_inputs();
    model_arb();
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_body();
    end
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    if_pend = 0; d_pend = 0; if_req = 1'b0; d_req = 1'b0;
    #1;
    check("rst_if_gnt", 32'(if_gnt), 0);     check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_if_valid", 32'(if_valid), 0); check("rst_d_valid", 32'(d_valid), 0);
    check("rst_mem_en", 32'(mem_en), 0);     check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);         check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_if_rdata", 32'(if_rdata), 0); check("rst_d_rdata", 32'(d_rdata), 0);
    g_cyc = -1; v_cyc = -1; starve = 0; e_if_rdata = '0; e_d_rdata = '0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; next_idle = 0;
    cycle_body();
  endtask

  initial begin
    int nif, nd;
    for (int unsigned i = 0; i < 256; i++) rmem[i] = fill(i);
    e_if_rdata = '0; e_d_rdata = '0;
    apply_reset(3);
    run(3);
    // single fetch of the preloaded word at 0x0010
    if_pend = 1; if_addr = 16'h0010;
    run(LAT + 4);
    // store then load-back of 0x0200
    d_pend = 1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    run(LAT + 4);
    d_pend = 1; d_we = 1'b0; d_addr = 16'h0200;
    run(LAT + 4);
    // contested in the same IDLE cycle
    if_pend = 1; if_addr = 16'h0020;
    d_pend = 1; d_we = 1'b0; d_addr = 16'h0030;
    run(2 * (LAT + 2) + 3);
    // reset during WAIT discards the fetch; next fetch has nominal latency
    if_pend = 1; if_addr = 16'h0040;
    run(3);
    apply_reset(2);
    run(2);
    if_pend = 1; if_addr = 16'h0010;
    run(LAT + 4);
    // random traffic
    p_if = 35; p_d = 35;
    run(2000);
    p_if = 0; p_d = 0;
    run(2 * (LAT + 2) + 4);
    // both requesters permanently high
    p_if = 100; p_d = 100;
    apply_reset(2);
    nif = 0; nd = 0;
    for (int i = 0; i < 600 && (nif + nd) < 20; i++) begin
      run(1);
      if (if_gnt) nif++;
      if (d_gnt)  nd++;
    end
    check("sat_fetch_grants", 32'(nif), GUARD ? 32'd4 : 32'd0);
    check("sat_data_grants", 32'(nd), GUARD ? 32'd16 : 32'd20);
    p_if = 0; p_d = 0;
    run(2 * (LAT + 2) + 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
